// File: rtl/gf180_mem_array.sv
// Banked SRAM array built from 512x8 macros with a valid/ready request port,
// byte enables, a backpressured two-stage read response and optional zero-fill.

module gf180mcu_fd_ip_sram__sram512x8m8wm1 (
`ifdef USE_POWER_PINS
    inout  wire        VDD,
    inout  wire        VSS,
`endif
    input  logic       CLK,
    input  logic       CEN,
    input  logic       GWEN,
    input  logic [7:0] WEN,
    input  logic [8:0] A,
    input  logic [7:0] D,
    output logic [7:0] Q
);
    logic [7:0] r_mem [512];
    logic [7:0] r_q;

    // Q only changes on a read, so it stays stable while the array is stalled
    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) begin
                for (int i = 0; i < 8; i++) begin
                    if (!WEN[i]) r_mem[A][i] <= D[i];
                end
            end else begin
                r_q <= r_mem[A];
            end
        end
    end

    assign Q = r_q;
endmodule

module gf180_mem_array #(
    parameter  int WIDTH_BYTES = 4,
    parameter  int DEPTH_BANKS = 2,
    parameter  int INIT_ZERO   = 1,
    localparam int AW          = 9 + $clog2(DEPTH_BANKS),
    localparam int DW          = 8 * WIDTH_BYTES
) (
`ifdef USE_POWER_PINS
    inout  wire                   VDD,
    inout  wire                   VSS,
`endif
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WIDTH_BYTES-1:0] req_be,
    input  logic [AW-1:0]          req_addr,
    input  logic [DW-1:0]          req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DW-1:0]          rsp_rdata,
    output logic                   init_done
);
    localparam int BW = (DEPTH_BANKS > 1) ? $clog2(DEPTH_BANKS) : 1;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [8:0]      r_cnt;
    logic            r_init_done;
    logic            w_clearing;
    logic            w_fill;

    logic            r_pend;
    logic [BW-1:0]   r_pend_bank;
    logic            r_out_valid;
    logic [DW-1:0]   r_rdata;

    logic [BW-1:0]   w_bank;
    logic            w_accept;
    logic            w_out_free;
    logic [DW-1:0]   w_rdata;
    logic [7:0]      w_q [DEPTH_BANKS][WIDTH_BYTES];

    generate
        if (DEPTH_BANKS > 1) begin : g_bank
            assign w_bank = req_addr[AW-1:9];
        end else begin : g_nobank
            assign w_bank = '0;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= (INIT_ZERO != 0) ? CLEAR : IDLE;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_clearing ? r_cnt + 9'd1 : '0;
            r_init_done <= (w_state_next == IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clearing   = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clearing = 1'b1;
                if (r_cnt == 9'd511) w_state_next = IDLE;
            end
            IDLE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_fill     = w_clearing && !RST;
    assign w_out_free = !r_out_valid || rsp_ready;
    assign req_ready  = r_init_done && (!r_pend || w_out_free);
    assign w_accept   = req_valid && req_ready;

    genvar b, c;
    generate
        for (b = 0; b < DEPTH_BANKS; b++) begin : g_row
            for (c = 0; c < WIDTH_BYTES; c++) begin : g_col
                logic       w_sel;
                logic       w_cen;
                logic       w_gwen;
                logic [7:0] w_wen;
                logic [8:0] w_a;
                logic [7:0] w_d;

                assign w_sel  = w_accept && (w_bank == BW'(b)) && (!req_we || req_be[c]);
                assign w_cen  = w_fill ? 1'b0 : !w_sel;
                assign w_gwen = w_fill ? 1'b0 : !req_we;
                assign w_wen  = w_fill ? 8'h00 : {8{!req_be[c]}};
                assign w_a    = w_fill ? r_cnt : req_addr[8:0];
                assign w_d    = w_fill ? 8'h00 : req_wdata[8*c +: 8];

                gf180mcu_fd_ip_sram__sram512x8m8wm1 u_sram (
`ifdef USE_POWER_PINS
                    .VDD  (VDD),
                    .VSS  (VSS),
`endif
                    .CLK  (CLK),
                    .CEN  (w_cen),
                    .GWEN (w_gwen),
                    .WEN  (w_wen),
                    .A    (w_a),
                    .D    (w_d),
                    .Q    (w_q[b][c])
                );
            end
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < WIDTH_BYTES; i++) begin
            w_rdata[8*i +: 8] = w_q[r_pend_bank][i];
        end
    end

    // pend advances into out whenever out is free; a new read may refill pend on the same edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend      <= 1'b0;
            r_pend_bank <= '0;
            r_out_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            if (r_pend && w_out_free) begin
                r_out_valid <= 1'b1;
                r_rdata     <= w_rdata;
            end else if (r_out_valid && rsp_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && !req_we) begin
                r_pend      <= 1'b1;
                r_pend_bank <= w_bank;
            end else if (w_out_free) begin
                r_pend      <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_out_valid;
    assign rsp_rdata = r_rdata;
    assign init_done = r_init_done;
endmodule

// File: tb/tb_gf180_mem_array.sv
// Directed self-checking bench for gf180_mem_array (4 bytes wide, 2 banks, zero-fill on).

module tb_gf180_mem_array;
    localparam int WB = 4;
    localparam int DB = 2;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [WB-1:0] req_be = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b1;
    wire           req_ready;
    wire           rsp_valid;
    wire  [DW-1:0] rsp_rdata;
    wire           init_done;
`ifdef USE_POWER_PINS
    wire           vdd = 1'b1;
    wire           vss = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    gf180_mem_array #(.WIDTH_BYTES(WB), .DEPTH_BANKS(DB), .INIT_ZERO(1)) dut (
`ifdef USE_POWER_PINS
        .VDD       (vdd),
        .VSS       (vss),
`endif
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic issue(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [WB-1:0] be);
        int n;
        @(negedge CLK);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL issue_timeout addr=%h: req_ready actual=0 required=1", addr);
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [DW-1:0] data, output int lat);
        lat = 0;
        @(negedge CLK);
        while (!rsp_valid && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        data = rsp_rdata;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_init(output int cnt, output logic saw_rsp);
        cnt = 0;
        saw_rsp = 1'b0;
        while (!init_done && cnt < 600) begin
            @(posedge CLK);
            cnt++;
            @(negedge CLK);
            if (rsp_valid) saw_rsp = 1'b1;
        end
    endtask

    task automatic test_reset;
        int cnt;
        logic seen;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_ready actual=%b required=0", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid actual=%b required=0", rsp_valid); end
        checks++;
        if (rsp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rsp_rdata actual=%h required=00000000", rsp_rdata); end
        checks++;
        if (init_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_init_done actual=%b required=0", init_done); end
        RST = 1'b0;
        cnt = 0;
        while (!init_done && cnt < 600) begin
            @(posedge CLK);
            cnt++;
            @(negedge CLK);
            if (cnt == 100) begin
                checks++;
                if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_req_ready actual=%b required=0", req_ready); end
            end
        end
        checks++;
        if (cnt != 512) begin failures++; $display("[TB] FAIL init_cycles actual=%0d required=512", cnt); end
        seen = init_done;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_init actual=%b required=1 (init_done=%b)", req_ready, seen); end
    endtask

    task automatic test_zero_read;
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] d;
        int lat;
        addrs[0] = 10'h000; addrs[1] = 10'h1FF; addrs[2] = 10'h200; addrs[3] = 10'h3FF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, addrs[i], '0, '0);
            get_rsp(d, lat);
            checks++;
            if (d !== 32'h0 || lat != 1) begin
                failures++;
                $display("[TB] FAIL zero_read addr=%h actual=%h lat=%0d required=00000000 lat=1", addrs[i], d, lat);
            end
        end
    endtask

    task automatic test_full_write;
        logic [DW-1:0] d;
        int lat;
        issue(1'b1, 10'h205, 32'hDEADBEEF, 4'b1111);
        issue(1'b0, 10'h205, '0, '0);
        get_rsp(d, lat);
        checks++;
        if (lat != 1) begin failures++; $display("[TB] FAIL read_latency actual=%0d required=1", lat); end
        checks++;
        if (d !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL full_write actual=%h required=deadbeef", d); end
    endtask

    task automatic test_partial_write;
        logic [DW-1:0] d;
        int lat;
        issue(1'b1, 10'h010, 32'hAABBCCDD, 4'b1111);
        issue(1'b1, 10'h010, 32'h11223344, 4'b0101);
        issue(1'b0, 10'h010, '0, '0);
        get_rsp(d, lat);
        checks++;
        if (d !== 32'hAA22CC44) begin failures++; $display("[TB] FAIL partial_write actual=%h required=aa22cc44", d); end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 10'h000, 32'h01020304, 4'b1111);
        issue(1'b1, 10'h200, 32'hA5A55A5A, 4'b1111);
        @(negedge CLK);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 10'h000;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_ready actual=%b required=1", req_ready); end
        @(posedge CLK);
        #1;
        req_addr = 10'h200;
        @(negedge CLK);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second_ready actual=%b required=1", req_ready); end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready cycle=%0d actual=%b required=0", i, req_ready); end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h01020304) begin
                failures++;
                $display("[TB] FAIL stall_hold cycle=%0d actual=%b/%h required=1/01020304", i, rsp_valid, rsp_rdata);
            end
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A55A5A) begin
            failures++;
            $display("[TB] FAIL b2b_second_word actual=%b/%h required=1/a5a55a5a", rsp_valid, rsp_rdata);
        end
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_resume actual=%b required=1", req_ready); end
        @(negedge CLK);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drained actual=%b required=0", rsp_valid); end
    endtask

    task automatic test_raw;
        logic [DW-1:0] d;
        int lat;
        @(negedge CLK);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 10'h3FF;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'b1111;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL raw_write_ready actual=%b required=1", req_ready); end
        @(posedge CLK);
        #1;
        req_we = 1'b0;
        @(negedge CLK);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL raw_read_ready actual=%b required=1", req_ready); end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        get_rsp(d, lat);
        checks++;
        if (d !== 32'hCAFEF00D || lat != 1) begin
            failures++;
            $display("[TB] FAIL read_after_write actual=%h lat=%0d required=cafef00d lat=1", d, lat);
        end
    endtask

    task automatic test_reset_midfill;
        int cnt;
        logic saw;
        logic [DW-1:0] d;
        int lat;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (300) @(negedge CLK);
        checks++;
        if (init_done !== 1'b0) begin failures++; $display("[TB] FAIL midfill_init_done actual=%b required=0", init_done); end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        wait_init(cnt, saw);
        checks++;
        if (cnt != 512) begin failures++; $display("[TB] FAIL refill_cycles actual=%0d required=512", cnt); end
        checks++;
        if (saw !== 1'b0) begin failures++; $display("[TB] FAIL refill_rsp_valid actual=1 required=0"); end
        issue(1'b0, 10'h205, '0, '0);
        get_rsp(d, lat);
        checks++;
        if (d !== 32'h0) begin failures++; $display("[TB] FAIL refill_zero actual=%h required=00000000", d); end
    endtask

    initial begin
        $display("[TB] starting gf180_mem_array bench");
        test_reset();
        test_zero_read();
        test_full_write();
        test_partial_write();
        test_back_to_back();
        test_raw();
        test_reset_midfill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
